mux_unstriping: RTL and testbench

//  Receive-side counterpart of the PHY striping stage. Merges two 32-bit lanes

---
 rtl/mux_unstriping.sv | 112 +++++++++++
 tb/tb_mux_unstriping.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/mux_unstriping.sv
// Two-lane receive unstriper: merges even (lane 0) and odd (lane 1) words into one ordered stream.
// Optional sticky drop flag err_overflow when UNSTRIPE_ERR_EN is defined.
module mux_unstriping #(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned AW    = 2
) (
    input  logic        clk_2f,
    input  logic        reset_L,
    input  logic [31:0] data_in0,
    input  logic        valid_in0,
    input  logic [31:0] data_in1,
    input  logic        valid_in1,
    output logic [31:0] data_out,
    output logic        valid_out,
    output logic        fifo_full0,
    output logic        fifo_full1
`ifdef UNSTRIPE_ERR_EN
    ,
    output logic        err_overflow
`endif
);

    localparam logic [AW:0] CntFull = (AW+1)'(DEPTH);

    logic [31:0]   mem0_q [DEPTH];
    logic [31:0]   mem1_q [DEPTH];
    logic [AW-1:0] wr0_q, rd0_q, wr1_q, rd1_q;
    logic [AW-1:0] wr0_d, rd0_d, wr1_d, rd1_d;
    logic [AW:0]   cnt0_q, cnt1_q, cnt0_d, cnt1_d;
    logic          sel_q, sel_d;
    logic [31:0]   data_q, data_d;
    logic          valid_q, valid_d;
    logic          pop0, pop1, push0, push1;

    always_comb begin
        // Only the selected lane may pop, so lane 1 never overtakes a missing lane 0 word.
        pop0  = !sel_q && (cnt0_q != '0);
        pop1  = sel_q && (cnt1_q != '0);
        push0 = valid_in0 && ((cnt0_q < CntFull) || pop0);
        push1 = valid_in1 && ((cnt1_q < CntFull) || pop1);

        wr0_d   = push0 ? wr0_q + AW'(1) : wr0_q;
        wr1_d   = push1 ? wr1_q + AW'(1) : wr1_q;
        rd0_d   = pop0 ? rd0_q + AW'(1) : rd0_q;
        rd1_d   = pop1 ? rd1_q + AW'(1) : rd1_q;
        cnt0_d  = cnt0_q + (AW+1)'(push0) - (AW+1)'(pop0);
        cnt1_d  = cnt1_q + (AW+1)'(push1) - (AW+1)'(pop1);

        sel_d   = sel_q;
        data_d  = data_q;
        valid_d = 1'b0;
        if (pop0) begin
            data_d  = mem0_q[rd0_q];
            valid_d = 1'b1;
            sel_d   = 1'b1;
        end else if (pop1) begin
            data_d  = mem1_q[rd1_q];
            valid_d = 1'b1;
            sel_d   = 1'b0;
        end
    end

    // Storage is not reset; pointers and counts define what is live.
    always_ff @(posedge clk_2f) begin
        if (reset_L && push0) mem0_q[wr0_q] <= data_in0;
        if (reset_L && push1) mem1_q[wr1_q] <= data_in1;
    end

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            wr0_q   <= '0;
            rd0_q   <= '0;
            wr1_q   <= '0;
            rd1_q   <= '0;
            cnt0_q  <= '0;
            cnt1_q  <= '0;
            sel_q   <= 1'b0;
            data_q  <= '0;
            valid_q <= 1'b0;
        end else begin
            wr0_q   <= wr0_d;
            rd0_q   <= rd0_d;
            wr1_q   <= wr1_d;
            rd1_q   <= rd1_d;
            cnt0_q  <= cnt0_d;
            cnt1_q  <= cnt1_d;
            sel_q   <= sel_d;
            data_q  <= data_d;
            valid_q <= valid_d;
        end
    end

    assign data_out   = data_q;
    assign valid_out  = valid_q;
    assign fifo_full0 = (cnt0_q == CntFull);
    assign fifo_full1 = (cnt1_q == CntFull);

`ifdef UNSTRIPE_ERR_EN
    logic err_q;

    always_ff @(posedge clk_2f) begin
        if (!reset_L) begin
            err_q <= 1'b0;
        end else if ((valid_in0 && !push0) || (valid_in1 && !push1)) begin
            err_q <= 1'b1;
        end
    end

    assign err_overflow = err_q;
`endif

endmodule

// File: tb/tb_mux_unstriping.sv
// Self-checking bench for mux_unstriping: directed vector table plus randomized traffic
// checked against a queue-based reference model.
module tb_mux_unstriping;

    localparam int DEPTH = 4;

    logic        clk_2f = 1'b0;
    logic        reset_L = 1'b0;
    logic [31:0] data_in0 = '0;
    logic        valid_in0 = 1'b0;
    logic [31:0] data_in1 = '0;
    logic        valid_in1 = 1'b0;
    logic [31:0] data_out;
    logic        valid_out;
    logic        fifo_full0;
    logic        fifo_full1;
`ifdef UNSTRIPE_ERR_EN
    logic        err_overflow;
`endif

    mux_unstriping #(
        .DEPTH (4),
        .AW    (2)
    ) dut (
        .clk_2f     (clk_2f),
        .reset_L    (reset_L),
        .data_in0   (data_in0),
        .valid_in0  (valid_in0),
        .data_in1   (data_in1),
        .valid_in1  (valid_in1),
        .data_out   (data_out),
        .valid_out  (valid_out),
        .fifo_full0 (fifo_full0),
        .fifo_full1 (fifo_full1)
`ifdef UNSTRIPE_ERR_EN
        ,
        .err_overflow (err_overflow)
`endif
    );

    always #5 clk_2f = ~clk_2f;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: one queue per lane, a lane selector and the output registers.
    logic [31:0] q0[$];
    logic [31:0] q1[$];
    bit          m_sel;
    bit          m_valid;
    logic [31:0] m_data;
    bit          m_err;

    function automatic void check(input string name, input logic [31:0] got,
                                  input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h at %0t", name, got, exp, $time);
        end
    endfunction

    task automatic step(input bit rst, input bit v0, input logic [31:0] d0,
                        input bit v1, input logic [31:0] d1);
        bit p0, p1, acc0, acc1;
        reset_L   = !rst;
        valid_in0 = v0;
        data_in0  = d0;
        valid_in1 = v1;
        data_in1  = d1;
        @(posedge clk_2f);
        #1;
        if (rst) begin
            q0.delete();
            q1.delete();
            m_sel   = 0;
            m_valid = 0;
            m_data  = '0;
            m_err   = 0;
        end else begin
            p0   = (m_sel == 0) && (q0.size() > 0);
            p1   = (m_sel == 1) && (q1.size() > 0);
            acc0 = v0 && ((q0.size() < DEPTH) || p0);
            acc1 = v1 && ((q1.size() < DEPTH) || p1);
            if ((v0 && !acc0) || (v1 && !acc1)) m_err = 1;
            m_valid = p0 || p1;
            if (p0) m_data = q0.pop_front();
            if (p1) m_data = q1.pop_front();
            if (m_valid) m_sel = !m_sel;
            if (acc0) q0.push_back(d0);
            if (acc1) q1.push_back(d1);
        end
        check("model_valid", 32'(valid_out), 32'(m_valid));
        check("model_data", data_out, m_data);
        check("model_full0", 32'(fifo_full0), 32'(q0.size() == DEPTH));
        check("model_full1", 32'(fifo_full1), 32'(q1.size() == DEPTH));
`ifdef UNSTRIPE_ERR_EN
        check("model_err", 32'(err_overflow), 32'(m_err));
`endif
    endtask

    typedef struct {
        bit          rst;
        bit          v0;
        logic [31:0] d0;
        bit          v1;
        logic [31:0] d1;
        bit          ev;
        logic [31:0] ed;
        bit          ef0;
        bit          ef1;
        bit          eerr;
        string       name;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input string name, input bit rst, input bit v0,
                                input logic [31:0] d0, input bit v1, input logic [31:0] d1,
                                input bit ev, input logic [31:0] ed, input bit ef0,
                                input bit ef1, input bit eerr);
        vec_t v;
        v.name = name; v.rst = rst; v.v0 = v0; v.d0 = d0; v.v1 = v1; v.d1 = d1;
        v.ev = ev; v.ed = ed; v.ef0 = ef0; v.ef1 = ef1; v.eerr = eerr;
        tbl.push_back(v);
    endfunction

    initial begin
        logic [31:0] pend0[$];
        logic [31:0] pend1[$];
        logic [31:0] next_word;
        int          pr0, pr1;
        bit          v0, v1;

        // Aligned stream: each word appears one cycle after its push.
        add("align_c0", 0, 1, 32'hA0, 0, 0, 0, 32'h0,  0, 0, 0);
        add("align_c1", 0, 0, 0, 1, 32'hA1, 1, 32'hA0, 0, 0, 0);
        add("align_c2", 0, 1, 32'hA2, 0, 0, 1, 32'hA1, 0, 0, 0);
        add("align_c3", 0, 0, 0, 1, 32'hA3, 1, 32'hA2, 0, 0, 0);
        add("align_c4", 0, 1, 32'hA4, 0, 0, 1, 32'hA3, 0, 0, 0);
        add("align_c5", 0, 0, 0, 1, 32'hA5, 1, 32'hA4, 0, 0, 0);
        add("align_c6", 0, 0, 0, 0, 0, 1, 32'hA5, 0, 0, 0);
        add("align_c7", 0, 0, 0, 0, 0, 0, 32'hA5, 0, 0, 0);
        // Skew: lane 1 early, nothing out until lane 0 arrives.
        add("skew_c0", 0, 0, 0, 1, 32'h11, 0, 32'hA5, 0, 0, 0);
        add("skew_c1", 0, 0, 0, 1, 32'h33, 0, 32'hA5, 0, 0, 0);
        add("skew_c2", 0, 1, 32'h00, 0, 0, 0, 32'hA5, 0, 0, 0);
        add("skew_c3", 0, 1, 32'h22, 0, 0, 1, 32'h00, 0, 0, 0);
        add("skew_c4", 0, 0, 0, 0, 0, 1, 32'h11, 0, 0, 0);
        add("skew_c5", 0, 0, 0, 0, 0, 1, 32'h22, 0, 0, 0);
        add("skew_c6", 0, 0, 0, 0, 0, 1, 32'h33, 0, 0, 0);
        add("skew_c7", 0, 0, 0, 0, 0, 0, 32'h33, 0, 0, 0);
        // Full lane 1, dropped fifth push, then release by lane 0.
        add("full_c0", 0, 0, 0, 1, 32'hB1, 0, 32'h33, 0, 0, 0);
        add("full_c1", 0, 0, 0, 1, 32'hB2, 0, 32'h33, 0, 0, 0);
        add("full_c2", 0, 0, 0, 1, 32'hB3, 0, 32'h33, 0, 0, 0);
        add("full_c3", 0, 0, 0, 1, 32'hB4, 0, 32'h33, 0, 1, 0);
        add("full_drop", 0, 0, 0, 1, 32'hB5, 0, 32'h33, 0, 1, 1);
        add("full_c5", 0, 1, 32'hAA, 0, 0, 0, 32'h33, 0, 1, 1);
        add("full_c6", 0, 0, 0, 0, 0, 1, 32'hAA, 0, 1, 1);
        add("full_c7", 0, 0, 0, 0, 0, 1, 32'hB1, 0, 0, 1);
        add("full_c8", 0, 0, 0, 0, 0, 0, 32'hB1, 0, 0, 1);
        // Mid-operation reset with B2..B4 buffered; they must never appear.
        add("mid_rst", 1, 1, 32'hDEAD, 1, 32'hBEEF, 0, 32'h0, 0, 0, 0);
        add("post_c0", 0, 1, 32'hC0, 0, 0, 0, 32'h0, 0, 0, 0);
        add("post_c1", 0, 0, 0, 1, 32'hC1, 1, 32'hC0, 0, 0, 0);
        add("post_c2", 0, 0, 0, 0, 0, 1, 32'hC1, 0, 0, 0);
        add("post_c3", 0, 0, 0, 0, 0, 0, 32'hC1, 0, 0, 0);

        // Reset held three cycles with random inputs.
        for (int i = 0; i < 3; i++) begin
            step(1, 1'($urandom), $urandom, 1'($urandom), $urandom);
            check("reset_valid", 32'(valid_out), 32'h0);
            check("reset_data", data_out, 32'h0);
            check("reset_full0", 32'(fifo_full0), 32'h0);
            check("reset_full1", 32'(fifo_full1), 32'h0);
        end

        for (int i = 0; i < tbl.size(); i++) begin
            step(tbl[i].rst, tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1);
            check({tbl[i].name, "_valid"}, 32'(valid_out), 32'(tbl[i].ev));
            check({tbl[i].name, "_data"}, data_out, tbl[i].ed);
            check({tbl[i].name, "_full0"}, 32'(fifo_full0), 32'(tbl[i].ef0));
            check({tbl[i].name, "_full1"}, 32'(fifo_full1), 32'(tbl[i].ef1));
`ifdef UNSTRIPE_ERR_EN
            check({tbl[i].name, "_err"}, 32'(err_overflow), 32'(tbl[i].eerr));
`endif
        end

        // Wrap: 20 alternating words, pointers wrap several times.
        step(1, 0, 0, 0, 0);
        for (int i = 0; i < 20; i++) begin
            step(0, (i % 2) == 0, 32'(i), (i % 2) == 1, 32'(i));
            if (i > 0) check("wrap_word", data_out, 32'(i - 1));
        end
        step(0, 0, 0, 0, 0);
        check("wrap_last", data_out, 32'd19);

        // Random skewed traffic with occasional overflow and reset.
        next_word = 32'h1000;
        pr0 = 50;
        pr1 = 50;
        for (int c = 0; c < 800; c++) begin
            if ((c % 50) == 0) begin
                pr0 = (($urandom_range(0, 2) == 0) ? 15 : (($urandom_range(0, 1) == 0) ? 50 : 95));
                pr1 = (($urandom_range(0, 2) == 0) ? 15 : (($urandom_range(0, 1) == 0) ? 50 : 95));
            end
            if (pend0.size() + pend1.size() < 10 && $urandom_range(0, 3) != 0) begin
                if (next_word[0]) pend1.push_back(next_word);
                else pend0.push_back(next_word);
                next_word++;
            end
            v0 = (pend0.size() > 0) && ($urandom_range(0, 99) < pr0);
            v1 = (pend1.size() > 0) && ($urandom_range(0, 99) < pr1);
            step($urandom_range(0, 199) == 0, v0, v0 ? pend0[0] : $urandom,
                 v1, v1 ? pend1[0] : $urandom);
            if (v0) void'(pend0.pop_front());
            if (v1) void'(pend1.pop_front());
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
